// File: rtl/pc_fetch_if.sv
// Fetch-stage bus bundle: decode redirect controls, program memory address/data, and fetch results.
// The master modport is the fetch stage itself; slave is the surrounding decode/memory side.
interface pc_fetch_if #(
  parameter int ADR_W  = 5,
  parameter int DATA_W = 16
);
  logic              stall;
  logic              jump_en;
  logic [ADR_W-1:0]  jump_adr;
  logic              call_en;
  logic              ret_en;
  logic [ADR_W-1:0]  pm_adr;
  logic [DATA_W-1:0] pm_data;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADR_W-1:0]  pc_out;
  logic              stk_ovf;
  logic              stk_unf;

  modport master (
    input  stall, jump_en, jump_adr, call_en, ret_en, pm_data,
    output pm_adr, instr, instr_valid, pc_out, stk_ovf, stk_unf
  );

  modport slave (
    output stall, jump_en, jump_adr, call_en, ret_en, pm_data,
    input  pm_adr, instr, instr_valid, pc_out, stk_ovf, stk_unf
  );
endinterface

// File: rtl/pc_fetch.sv
// Instruction fetch stage: program counter, instruction register and a small return-address stack.
// Define PC_FETCH_STACK_CHECK_EN to suppress calls on a full stack / returns on an empty one and raise sticky flags.
module pc_fetch #(
  parameter int ADR_W       = 5,
  parameter int DATA_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  pc_fetch_if.master bus
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [ADR_W-1:0]  stack_q [STACK_DEPTH];
  logic [ADR_W-1:0]  stack_d [STACK_DEPTH];
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;
`ifdef PC_FETCH_STACK_CHECK_EN
  logic              stk_ovf_q, stk_ovf_d;
  logic              stk_unf_q, stk_unf_d;
`endif

  // Any taken redirect clears instr_valid so the sequentially fetched word becomes a bubble.
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    sp_d          = sp_q;
    stack_d       = stack_q;
`ifdef PC_FETCH_STACK_CHECK_EN
    stk_ovf_d     = stk_ovf_q;
    stk_unf_d     = stk_unf_q;
`endif
    top_idx       = IDX_W'(sp_q - 1'b1);
    push_idx      = IDX_W'(sp_q);

    if (!bus.stall) begin
      instr_d       = bus.pm_data;
      instr_valid_d = 1'b1;
      pc_d          = pc_q + 1'b1;

      if (bus.ret_en) begin
        if (sp_q != '0) begin
          pc_d          = stack_q[top_idx];
          sp_d          = sp_q - 1'b1;
          instr_valid_d = 1'b0;
        end else begin
`ifdef PC_FETCH_STACK_CHECK_EN
          stk_unf_d     = 1'b1;
`else
          pc_d          = '0;
          instr_valid_d = 1'b0;
`endif
        end
      end else if (bus.call_en) begin
        if (sp_q != SP_FULL) begin
          stack_d[push_idx] = pc_q;
          sp_d              = sp_q + 1'b1;
          pc_d              = bus.jump_adr;
          instr_valid_d     = 1'b0;
        end else begin
`ifdef PC_FETCH_STACK_CHECK_EN
          stk_ovf_d         = 1'b1;
`else
          pc_d              = bus.jump_adr;
          instr_valid_d     = 1'b0;
`endif
        end
      end else if (bus.jump_en) begin
        pc_d          = bus.jump_adr;
        instr_valid_d = 1'b0;
      end
    end
  end

  // Synchronous active-low reset clears the PC, instruction register and the whole stack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      sp_q          <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
`ifdef PC_FETCH_STACK_CHECK_EN
      stk_ovf_q     <= 1'b0;
      stk_unf_q     <= 1'b0;
`endif
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      sp_q          <= sp_d;
      stack_q       <= stack_d;
`ifdef PC_FETCH_STACK_CHECK_EN
      stk_ovf_q     <= stk_ovf_d;
      stk_unf_q     <= stk_unf_d;
`endif
    end
  end

  assign bus.pm_adr      = pc_q;
  assign bus.pc_out      = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
`ifdef PC_FETCH_STACK_CHECK_EN
  assign bus.stk_ovf     = stk_ovf_q;
  assign bus.stk_unf     = stk_unf_q;
`else
  assign bus.stk_ovf     = 1'b0;
  assign bus.stk_unf     = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic against a queue-based fetch model.
// Honours PC_FETCH_STACK_CHECK_EN the same way the design does.
module tb_pc_fetch;

  localparam int ADR_W       = 5;
  localparam int DATA_W      = 16;
  localparam int STACK_DEPTH = 4;
  localparam int MEM_N       = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_fetch_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  pc_fetch #(
    .ADR_W(ADR_W),
    .DATA_W(DATA_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  logic [DATA_W-1:0] mem [MEM_N];
  assign bus.pm_data = mem[bus.pm_adr];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: PC as an integer, return addresses as a queue.
  int          m_pc;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_ovf;
  bit          m_unf;
  int          m_stk[$];

`ifdef PC_FETCH_STACK_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  function automatic logic [28:0] exp_vec();
    return {5'(m_pc), 5'(m_pc), m_instr, m_valid, m_ovf, m_unf};
  endfunction

  function automatic logic [28:0] act_vec();
    return {bus.pm_adr, bus.pc_out, bus.instr, bus.instr_valid, bus.stk_ovf, bus.stk_unf};
  endfunction

  // Drives one clock of inputs, advances the model, and returns #1 after the rising edge.
  task automatic step(input bit rst, input bit st, input bit j, input bit c, input bit r,
                      input logic [4:0] adr);
    int nxt;
    bit redirect;
    rst_n        = !rst;
    bus.stall    = st;
    bus.jump_en  = j;
    bus.call_en  = c;
    bus.ret_en   = r;
    bus.jump_adr = adr;
    if (rst) begin
      m_pc = 0; m_instr = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
      m_stk.delete();
    end else if (!st) begin
      redirect = 0;
      nxt      = (m_pc + 1) % MEM_N;
      if (r) begin
        if (m_stk.size() > 0) begin
          nxt = m_stk.pop_back(); redirect = 1;
        end else if (CHECK_EN) begin
          m_unf = 1;
        end else begin
          nxt = 0; redirect = 1;
        end
      end else if (c) begin
        if (m_stk.size() < STACK_DEPTH) begin
          m_stk.push_back(m_pc); nxt = int'(adr); redirect = 1;
        end else if (CHECK_EN) begin
          m_ovf = 1;
        end else begin
          nxt = int'(adr); redirect = 1;
        end
      end else if (j) begin
        nxt = int'(adr); redirect = 1;
      end
      m_instr = mem[m_pc];
      m_valid = !redirect;
      m_pc    = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    idle(3);
    step(0, 0, 0, 1, 0, 5'd9);
    idle(2);
    step(1, 0, 1, 1, 0, 5'd17);
    tests_run++;
    if (act_vec() !== 29'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got %h expected %h", act_vec(), 29'h0);
    end
  endtask

  task automatic test_free_run();
    logic [21:0] want;
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'(i);
    step(1, 0, 0, 0, 0, 5'd0);
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0, 0, 0, 5'd0);
      want = {5'(k % MEM_N), 16'((k - 1) % MEM_N), 1'b1};
      tests_run++;
      if ({bus.pm_adr, bus.instr, bus.instr_valid} !== want || act_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL free_run cycle %0d: got %h expected %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_jump();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    idle(12);
    step(0, 0, 1, 0, 0, 5'd30);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd30, 1'b0, mem[12]}) begin
      tests_failed++;
      $display("[TB] FAIL jump_bubble: got %h expected %h", {bus.pm_adr, bus.instr_valid, bus.instr}, {5'd30, 1'b0, mem[12]});
    end
    step(0, 0, 0, 0, 0, 5'd0);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd31, 1'b1, mem[30]} || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL jump_target: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_call_ret();
    logic [5:0] want_empty;
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    idle(2);
    step(0, 0, 0, 1, 0, 5'd29);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid} !== {5'd29, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL call_redirect: got %h expected %h", {bus.pm_adr, bus.instr_valid}, {5'd29, 1'b0});
    end
    step(0, 0, 0, 0, 0, 5'd0);
    step(0, 0, 0, 0, 1, 5'd0);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd2, 1'b0, mem[30]}) begin
      tests_failed++;
      $display("[TB] FAIL ret_redirect: got %h expected %h", {bus.pm_adr, bus.instr_valid, bus.instr}, {5'd2, 1'b0, mem[30]});
    end
    step(0, 0, 0, 0, 0, 5'd0);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd3, 1'b1, mem[2]}) begin
      tests_failed++;
      $display("[TB] FAIL ret_target: got %h expected %h", {bus.pm_adr, bus.instr_valid, bus.instr}, {5'd3, 1'b1, mem[2]});
    end
    // Stack is empty again, so this return exercises the underflow behaviour.
    step(0, 0, 0, 0, 1, 5'd0);
    want_empty = CHECK_EN ? {5'd4, 1'b1} : {5'd0, 1'b0};
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid} !== want_empty || bus.stk_unf !== CHECK_EN || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL ret_empty: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    idle(5);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 1, 0, 0, 5'd20);
      tests_run++;
      if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd5, 1'b1, mem[4]}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold cycle %0d: got %h expected %h", k, {bus.pm_adr, bus.instr_valid, bus.instr}, {5'd5, 1'b1, mem[4]});
      end
    end
    step(0, 0, 0, 0, 0, 5'd0);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.instr} !== {5'd6, 1'b1, mem[5]}) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got %h expected %h", {bus.pm_adr, bus.instr_valid, bus.instr}, {5'd6, 1'b1, mem[5]});
    end
  endtask

  task automatic test_ret_call_priority();
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    idle(7);
    step(0, 0, 0, 1, 0, 5'd20);
    step(0, 0, 0, 0, 0, 5'd0);
    step(0, 0, 1, 1, 1, 5'd25);
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid} !== {5'd7, 1'b0} || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL ret_over_call: got %h expected %h", act_vec(), exp_vec());
    end
    step(0, 0, 0, 0, 0, 5'd0);
    step(0, 0, 0, 0, 1, 5'd0);
    tests_run++;
    if (act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL ret_call_no_push: got %h expected %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    int pops [4] = '{14, 12, 10, 0};
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 5'(10 + 2 * i));
    tests_run++;
    if ({bus.pm_adr, bus.instr_valid, bus.stk_ovf} !== (CHECK_EN ? {5'd17, 1'b1, 1'b1} : {5'd18, 1'b0, 1'b0})
        || act_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL fifth_call: got %h expected %h", act_vec(), exp_vec());
    end
    idle(3);
    tests_run++;
    if (bus.stk_ovf !== CHECK_EN) begin
      tests_failed++;
      $display("[TB] FAIL ovf_sticky: got %b expected %b", bus.stk_ovf, CHECK_EN);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 5'd0);
      tests_run++;
      if (bus.pm_adr !== 5'(pops[i]) || act_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL pop %0d: got %h expected %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit rst, st, j, c, r;
    for (int i = 0; i < MEM_N; i++) mem[i] = 16'($urandom);
    step(1, 0, 0, 0, 0, 5'd0);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 4) == 0);
      j   = ($urandom_range(0, 5) == 0);
      c   = ($urandom_range(0, 5) == 0);
      r   = ($urandom_range(0, 6) == 0);
      step(rst, st, j, c, r, 5'($urandom));
      tests_run++;
      if (act_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random cycle %0d: got %h expected %h", k, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.stall    = 1'b0;
    bus.jump_en  = 1'b0;
    bus.call_en  = 1'b0;
    bus.ret_en   = 1'b0;
    bus.jump_adr = '0;
    for (int i = 0; i < MEM_N; i++) mem[i] = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_free_run();
    test_jump();
    test_call_ret();
    test_stall();
    test_ret_call_priority();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
- Instruction fetch stage sitting directly upstream of the 32x16 program memory.
- Owns the program counter and drives the memory address. Registers the returned 16-bit word into an instruction register for decode.
- Applies jump, call and return redirects from decode, with a small hardware return-address stack.
- Program memory read is combinational: the word for pm_adr is available in the same cycle.

Parameters:
- ADR_W, 5, program address width (memory depth 2**ADR_W).
- DATA_W, 16, instruction word width.
- STACK_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the fetch stage (decode/execute busy).
- jump_en  in  1  load PC with jump_adr.
- jump_adr  in  ADR_W  jump/call target.
- call_en  in  1  push return address, load PC with jump_adr.
- ret_en  in  1  pop return address into PC.
- pm_adr  out  ADR_W  address to program memory; equals PC register.
- pm_data  in  DATA_W  word from program memory.
- instr  out  DATA_W  instruction register.
- instr_valid  out  1  instr holds a valid fetched word.
- pc_out  out  ADR_W  current PC (debug/trace).
- stk_ovf  out  1  stack overflow flag (see Optional Feature).
- stk_unf  out  1  stack underflow flag (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous, active-low; rst_n low at a rising edge clears all state.
  - Values: pc=0, instr=0, instr_valid=0, sp=0, stack entries=0, stk_ovf=0, stk_unf=0.
  - Reset mid-operation discards any pending redirect and the stack contents.
- pm_adr and pc_out are driven combinationally from the pc register. instr and instr_valid are registered.
- Each non-stalled cycle, instr <= pm_data (the word at current pc). Next-pc priority, high to low:
  - ret_en: pc <= stack[sp-1]; sp <= sp-1.
  - call_en: stack[sp] <= pc; sp <= sp+1; pc <= jump_adr. pc is already the address after the call, because the call word sits in instr at pc-1.
  - jump_en: pc <= jump_adr.
  - none: pc <= pc+1, modulo 2**ADR_W; 31 wraps to 0 with no flag.
- Redirect flush: when ret, call or jump is taken, the word fetched that cycle is sequentially wrong.
  - instr_valid <= 0 next cycle (one bubble); instr is still loaded but marked invalid.
  - With no redirect, instr_valid <= 1.
- Stall: stall=1 holds pc, instr, instr_valid, sp and stack unchanged.
  - Redirect inputs are ignored while stalled; decode holds them until stall drops.
- Simultaneous redirects resolve by the priority above; lower-priority requests are dropped, not queued.
- Redirect latency: target address appears on pm_adr the cycle after the request. The target instruction is valid in instr two cycles after the request.
- Stack full (sp==STACK_DEPTH) on call, or empty (sp==0) on ret: see Optional Feature.
- jump_adr is taken as-is; all ADR_W values are legal.

Optional Feature:
- Macro: PC_FETCH_STACK_CHECK_EN.
- Defined:
  - Call when full: push and redirect suppressed; behaves as no redirect, pc increments; stk_ovf set.
  - Ret when empty: redirect suppressed likewise; stk_unf set.
  - Both flags are sticky until reset.
- Not defined:
  - stk_ovf and stk_unf are tied 0.
  - Call when full still redirects pc but drops the push; sp stays at STACK_DEPTH.
  - Ret when empty loads pc <= 0; sp stays 0.

Test Plan:
- Reset then free-run, no redirects, memory word = address -> pm_adr 0,1,2..., instr_valid rises the cycle after reset release, instr trails pm_adr by one cycle, pc wraps 31->0.
- jump_en=1, jump_adr=30 while pc=12 -> pm_adr=30 next cycle, one cycle with instr_valid=0, then instr = word 30.
- call_en to 29 at pc=2, later ret_en -> stack holds 2, pc returns to 2, sp back to 0, one bubble per redirect.
- stall=1 for 3 cycles with jump_en asserted -> pc, instr, instr_valid frozen, jump ignored; after release pc increments normally.
- ret_en and call_en together with sp=1, stack[0]=7 -> pc=7, sp=0, no push.
- 5 nested calls with STACK_DEPTH=4:
  - With PC_FETCH_STACK_CHECK_EN: 5th call suppressed, stk_ovf=1 sticky.
  - Without it: 5th call redirects, stk_ovf=0, sp=4.
